// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared state encoding, segment constants and operand-width limits
// for the sequential adder controller and its 7-segment decoder.
package adder_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_CALC,
        ST_SHOW,
        ST_SWEEP
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // The sum must fit a single hex digit, which caps the operand width at 3 bits.
    localparam int N_MIN = 1;
    localparam int N_MAX = 3;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: 4-bit value to an active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg
    import adder_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: button-driven two-operand adder with registered sum and 7-segment readout.
// Define ADDER_SEQ_AUTO_SWEEP_EN to build the auto-sweep mode that walks every operand pair.
module adder_seq_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_sw,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_auto,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic [N:0]   o_sum,
    output logic         o_valid,
    output logic [6:0]   o_HEX
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_width
        $error("adder_seq_ctrl: N must lie within N_MIN..N_MAX");
    end

    state_t       state;
    state_t       state_n;
    logic         load_q;
    logic         load_rise;
    logic [N-1:0] a_n;
    logic [N-1:0] b_n;
    logic [N:0]   sum_n;
    logic         valid_n;
    logic [6:0]   seg;

    // load_q resets high so a button already held at reset release is not a new press.
    assign load_rise = i_load & ~load_q;

`ifdef ADDER_SEQ_AUTO_SWEEP_EN
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] dwell_cnt_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt_n;
        end
    end
`else
    localparam int UNUSED_DWELL = DWELL;

    logic unused_auto;
    assign unused_auto = i_auto;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            load_q  <= 1'b1;
            o_a     <= '0;
            o_b     <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_n;
            load_q  <= i_load;
            o_a     <= a_n;
            o_b     <= b_n;
            o_sum   <= sum_n;
            o_valid <= valid_n;
        end
    end

    // Sequencing: clear overrides everything, then each state reacts to load presses or auto.
    // o_valid is raised on the first SHOW edge so it trails the CALC edge that registers the sum.
    always_comb begin
        state_n = state;
        a_n     = o_a;
        b_n     = o_b;
        sum_n   = o_sum;
        valid_n = o_valid;
`ifdef ADDER_SEQ_AUTO_SWEEP_EN
        dwell_cnt_n = dwell_cnt;
`endif
        if (i_clear) begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
`ifdef ADDER_SEQ_AUTO_SWEEP_EN
                    if (i_auto) begin
                        state_n     = ST_SWEEP;
                        a_n         = '0;
                        b_n         = '0;
                        sum_n       = '0;
                        valid_n     = 1'b1;
                        dwell_cnt_n = '0;
                    end else
`endif
                    if (load_rise) begin
                        a_n     = i_sw;
                        state_n = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (load_rise) begin
                        b_n     = i_sw;
                        state_n = ST_CALC;
                    end
                end
                ST_CALC: begin
                    sum_n   = {1'b0, o_a} + {1'b0, o_b};
                    state_n = ST_SHOW;
                end
                ST_SHOW: begin
                    valid_n = 1'b1;
`ifdef ADDER_SEQ_AUTO_SWEEP_EN
                    if (i_auto) begin
                        state_n     = ST_SWEEP;
                        a_n         = '0;
                        b_n         = '0;
                        sum_n       = '0;
                        dwell_cnt_n = '0;
                    end else
`endif
                    if (load_rise) begin
                        a_n     = i_sw;
                        valid_n = 1'b0;
                        state_n = ST_WAIT_B;
                    end
                end
                ST_SWEEP: begin
`ifdef ADDER_SEQ_AUTO_SWEEP_EN
                    // b is the inner counter; a steps only when b wraps.
                    if (dwell_cnt == CW'(DWELL - 1)) begin
                        dwell_cnt_n = '0;
                        if (!i_auto) begin
                            state_n = ST_IDLE;
                            valid_n = 1'b0;
                        end else begin
                            b_n = o_b + N'(1);
                            if (o_b == '1) begin
                                a_n = o_a + N'(1);
                            end
                            sum_n   = {1'b0, a_n} + {1'b0, b_n};
                            valid_n = 1'b1;
                        end
                    end else begin
                        dwell_cnt_n = dwell_cnt + CW'(1);
                    end
`else
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
`endif
                end
                default: begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    hex_to_7seg u_hex (
        .digit(4'(o_sum)),
        .seg  (seg)
    );

    assign o_HEX = o_valid ? seg : SEG_BLANK;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized self-checking bench for adder_seq_ctrl against a scenario-level model.
// The sweep scenario is exercised when ADDER_SEQ_AUTO_SWEEP_EN is defined, otherwise i_auto must be ignored.
module tb_adder_seq_ctrl;

    localparam int N     = 3;
    localparam int DWELL = 4;
    localparam int NV    = 2 ** N;
    localparam int SW    = N + 1;
    localparam int VW    = 3 * N + 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic         load;
    logic         clear;
    logic         auto;
    logic [N-1:0] o_a;
    logic [N-1:0] o_b;
    logic [N:0]   o_sum;
    logic         o_valid;
    logic [6:0]   o_hex;
    logic [VW-1:0] obs;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [N-1:0] m_a;
    logic [N-1:0] m_b;
    logic [N:0]   m_sum;
    logic         m_valid;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    adder_seq_ctrl #(.N(N), .DWELL(DWELL)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sw   (sw),
        .i_load (load),
        .i_clear(clear),
        .i_auto (auto),
        .o_a    (o_a),
        .o_b    (o_b),
        .o_sum  (o_sum),
        .o_valid(o_valid),
        .o_HEX  (o_hex)
    );

    always #5 clk = ~clk;

    assign obs = {o_a, o_b, o_sum, o_valid, o_hex};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected visible outputs: the display shows the sum digit only while valid.
    function automatic logic [VW-1:0] expect_vec(input logic [N-1:0] a, input logic [N-1:0] b,
                                                 input logic [N:0] s, input logic v);
        logic [6:0] h;
        h = v ? seg_ref[4'(s)] : 7'h7F;
        return {a, b, s, v, h};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return expect_vec(m_a, m_b, m_sum, m_valid);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic ld, input logic clr, input logic au);
        sw    = v;
        load  = ld;
        clear = clr;
        auto  = au;
    endtask

    // One button press: high for one edge, then low for one edge so the next press is a fresh rise.
    task automatic press_load(input logic [N-1:0] v);
        applyStimulus(v, 1'b1, 1'b0, auto);
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        m_a = '0; m_b = '0; m_sum = '0; m_valid = 1'b0;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs, model_vec());
        end
        n_compared++;
        if (o_hex !== 7'h7F) begin
            n_mismatched++;
            $display("[TB] FAIL reset_hex_blank: got %h expected 7f", o_hex);
        end
        rst = 1'b0;
        tick();
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_directed();
        int ta [3] = '{5, 7, 0};
        int tb [3] = '{6, 7, 0};
        int es [3] = '{11, 14, 0};
        logic [6:0] eh [3] = '{7'h03, 7'h06, 7'h40};
        for (int i = 0; i < 3; i++) begin
            press_load(N'(ta[i]));
            m_a = N'(ta[i]);
            m_valid = 1'b0;
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL directed_capture_a[%0d]: got %h expected %h", i, obs, model_vec());
            end
            press_load(N'(tb[i]));
            m_b = N'(tb[i]);
            m_sum = SW'(ta[i] + tb[i]);
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL directed_one_edge_after_b[%0d]: got %h expected %h", i, obs, model_vec());
            end
            tick();
            m_valid = 1'b1;
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL directed_two_edges_after_b[%0d]: got %h expected %h", i, obs, model_vec());
            end
            n_compared++;
            if (o_sum !== SW'(es[i]) || o_hex !== eh[i]) begin
                n_mismatched++;
                $display("[TB] FAIL directed_sum_hex[%0d]: got sum %0d hex %h expected sum %0d hex %h",
                         i, o_sum, o_hex, es[i], eh[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom_range(0, NV - 1));
            rb = N'($urandom_range(0, NV - 1));
            press_load(ra);
            m_a = ra;
            m_valid = 1'b0;
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL random_capture_a[%0d]: got %h expected %h", i, obs, model_vec());
            end
            repeat ($urandom_range(0, 2)) tick();
            press_load(rb);
            m_b = rb;
            m_sum = SW'(int'(ra) + int'(rb));
            tick();
            m_valid = 1'b1;
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL random_result[%0d]: got %h expected %h", i, obs, model_vec());
            end
            repeat ($urandom_range(0, 2)) tick();
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL random_show_hold[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_held_load();
        logic [N-1:0] first;
        logic [N-1:0] rb;
        pulse_clear();
        tick();
        first = N'($urandom_range(0, NV - 1));
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 0) ? first : N'($urandom_range(0, NV - 1)), 1'b1, 1'b0, 1'b0);
            tick();
            if (i == 0) m_a = first;
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL held_load_single_capture[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        load = 1'b0;
        tick();
        rb = N'($urandom_range(0, NV - 1));
        press_load(rb);
        m_b = rb;
        m_sum = SW'(int'(first) + int'(rb));
        tick();
        m_valid = 1'b1;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL held_load_then_b: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_clear_priority();
        logic [N-1:0] ra;
        logic [N-1:0] rc;
        logic [N-1:0] rd;
        ra = N'($urandom_range(0, NV - 1));
        press_load(ra);
        m_a = ra;
        m_valid = 1'b0;
        applyStimulus(~m_b, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        tick();
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL clear_beats_load: got %h expected %h", obs, model_vec());
        end
        rc = N'($urandom_range(0, NV - 1));
        press_load(rc);
        m_a = rc;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL clear_lands_in_idle: got %h expected %h", obs, model_vec());
        end
        rd = N'($urandom_range(0, NV - 1));
        press_load(rd);
        m_b = rd;
        m_sum = SW'(int'(rc) + int'(rd));
        tick();
        m_valid = 1'b1;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL clear_recovery_sum: got %h expected %h", obs, model_vec());
        end
        pulse_clear();
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL clear_from_show: got %h expected %h", obs, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ra;
        press_load(N'(3));
        press_load(N'(4));
        tick();
        applyStimulus(N'(6), 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        m_a = '0; m_b = '0; m_sum = '0; m_valid = 1'b0;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL reset_from_show: got %h expected %h", obs, model_vec());
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL held_through_reset_no_capture: got %h expected %h", obs, model_vec());
        end
        load = 1'b0;
        tick();
        ra = N'($urandom_range(1, NV - 1));
        press_load(ra);
        m_a = ra;
        n_compared++;
        if (obs !== model_vec()) begin
            n_mismatched++;
            $display("[TB] FAIL capture_after_reset: got %h expected %h", obs, model_vec());
        end
    endtask

`ifdef ADDER_SEQ_AUTO_SWEEP_EN
    task automatic test_sweep();
        int k;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [VW-1:0] ev;
        bit exited;
        pulse_clear();
        auto = 1'b1;
        tick();
        for (int c = 0; c <= NV * NV * DWELL; c++) begin
            k  = (c / DWELL) % (NV * NV);
            ea = N'(k / NV);
            eb = N'(k % NV);
            ev = expect_vec(ea, eb, SW'(int'(ea) + int'(eb)), 1'b1);
            n_compared++;
            if (obs !== ev) begin
                n_mismatched++;
                $display("[TB] FAIL sweep_cycle[%0d]: got %h expected %h", c, obs, ev);
            end
            if (c < NV * NV * DWELL) tick();
        end
        auto = 1'b0;
        exited = 1'b0;
        for (int t = 0; t < 2 * DWELL && !exited; t++) begin
            tick();
            if (o_valid === 1'b0) exited = 1'b1;
        end
        n_compared++;
        if (!exited) begin
            n_mismatched++;
            $display("[TB] FAIL sweep_exit: got valid %b expected 0 within %0d cycles", o_valid, 2 * DWELL);
        end
        m_a = '0; m_b = '0; m_sum = '0; m_valid = 1'b0;
    endtask
`else
    task automatic test_auto_ignored();
        logic [N-1:0] rb;
        rb = N'($urandom_range(0, NV - 1));
        press_load(rb);
        m_b = rb;
        m_sum = SW'(int'(m_a) + int'(rb));
        tick();
        m_valid = 1'b1;
        auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL auto_ignored_show[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_compared++;
            if (obs !== model_vec()) begin
                n_mismatched++;
                $display("[TB] FAIL auto_ignored_idle[%0d]: got %h expected %h", i, obs, model_vec());
            end
        end
        auto = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_random();
        test_held_load();
        test_clear_priority();
        test_reset_mid();
`ifdef ADDER_SEQ_AUTO_SWEEP_EN
        test_sweep();
`else
        test_auto_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
